// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC bus scheduler and its arbiter.
package rtc_bus_pkg;

   // One full bus transaction walks these states in order.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_GAP1 = 3'd2,
      ST_DATA = 3'd3,
      ST_GAP2 = 3'd4,
      ST_DONE = 3'd5
   } state_e;

   // Requester port indices.
   localparam int PORT_INIT = 0;
   localparam int PORT_WR   = 1;
   localparam int PORT_RD   = 2;

   // {cs, rd, wr} with every active-low strobe released.
   localparam logic [2:0] STROBE_IDLE = 3'b111;

   // Converts a one-hot grant into a port index (port 0 when nothing is set).
   function automatic logic [1:0] port_idx(input logic [2:0] onehot);
      case (onehot)
         3'b010:  return 2'd1;
         3'b100:  return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/rtc_bus_arb_pick.sv
// Combinational arbiter: port 0 always wins, ports 1 and 2 share round-robin.
// ptr = 0 favours port 1, ptr = 1 favours port 2.
module rtc_bus_arb_pick
   import rtc_bus_pkg::*;
(
   input  logic [2:0] req,
   input  logic       ptr,
   output logic [2:0] gnt,
   output logic       ptr_next
);

   // Pick one requester; the pointer only moves after a port 1 or port 2 win.
   always_comb begin
      gnt      = 3'b000;
      ptr_next = ptr;
      if (req[PORT_INIT]) begin
         gnt[PORT_INIT] = 1'b1;
      end else if (req[PORT_WR] && req[PORT_RD]) begin
         if (ptr) gnt[PORT_RD] = 1'b1;
         else     gnt[PORT_WR] = 1'b1;
         ptr_next = ~ptr;
      end else if (req[PORT_WR]) begin
         gnt[PORT_WR] = 1'b1;
         ptr_next     = 1'b1;
      end else if (req[PORT_RD]) begin
         gnt[PORT_RD] = 1'b1;
         ptr_next     = 1'b0;
      end
   end

endmodule

// File: rtl/rtc_bus_scheduler.sv
// Shares the multiplexed RTC bus between the init sequencer, register writer
// and register reader, running one address+data transaction per grant.
// Pad outputs are registered from the current state, so they trail the state
// register by one cycle; a request sampled at edge E0 shows ADDR from E0+1.
module rtc_bus_scheduler
   import rtc_bus_pkg::*;
#(
   parameter int unsigned T_PULSE = 7,
   parameter int unsigned T_GAP   = 7
) (
   input  logic        clk_i,
   input  logic        reset,
   input  logic [2:0]  req_i,
   input  logic [2:0]  rnw_i,
   input  logic [23:0] addr_i,
   input  logic [23:0] wdata_i,
   output logic [2:0]  gnt_o,
   output logic [2:0]  done_o,
   output logic [7:0]  rdata_o,
   output logic        busy_o,
   output logic [7:0]  bus_o,
   output logic        bus_oe_o,
   input  logic [7:0]  bus_i,
   output logic        ad_o,
   output logic        cs_o,
   output logic        rd_o,
   output logic        wr_o
);

   localparam logic [3:0] PULSE_LEN = 4'(T_PULSE);
   localparam logic [3:0] GAP_LEN   = 4'(T_GAP);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        phase_end;
   logic        take_grant;

   logic        ptr_q;
   logic [2:0]  gnt_q;
   logic        rnw_q;
   logic [7:0]  addr_q;
   logic [7:0]  wdata_q;

   logic [2:0]  pick_gnt;
   logic        pick_ptr;
   logic [1:0]  pick_idx;

   logic        last_data_q;
   logic [2:0]  strobe_d;
   logic        ad_d;
   logic        oe_d;
   logic [7:0]  bus_d;

   rtc_bus_arb_pick u_arb (
      .req      (req_i),
      .ptr      (ptr_q),
      .gnt      (pick_gnt),
      .ptr_next (pick_ptr)
   );

   assign pick_idx  = port_idx(pick_gnt);
   assign phase_end = (cnt_q == 4'd1);

   // Next-state and phase counter: each phase loads its length and counts down to 1.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no branch can leave one unassigned and infer a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      take_grant = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|req_i) begin
               state_d    = ST_ADDR;
               cnt_d      = PULSE_LEN;
               take_grant = 1'b1;
            end
         end
         ST_ADDR: begin
            if (phase_end) begin
               state_d = ST_GAP1;
               cnt_d   = GAP_LEN;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_GAP1: begin
            if (phase_end) begin
               state_d = ST_DATA;
               cnt_d   = PULSE_LEN;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_DATA: begin
            if (phase_end) begin
               state_d = ST_GAP2;
               cnt_d   = GAP_LEN;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_GAP2: begin
            if (phase_end) begin
               state_d = ST_DONE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // State and phase counter registers.
   always_ff @(posedge clk_i or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Capture the winning port's request and advance the round-robin pointer.
   always_ff @(posedge clk_i or negedge reset) begin
      if (!reset) begin
         // NOTE: captured request fields are reset too, so a transaction aborted by reset leaves nothing behind.
         ptr_q   <= 1'b0;
         gnt_q   <= 3'b000;
         rnw_q   <= 1'b0;
         addr_q  <= 8'h00;
         wdata_q <= 8'h00;
      end else if (take_grant) begin
         ptr_q   <= pick_ptr;
         gnt_q   <= pick_gnt;
         rnw_q   <= rnw_i[pick_idx];
         addr_q  <= addr_i[{pick_idx, 3'b000} +: 8];
         wdata_q <= wdata_i[{pick_idx, 3'b000} +: 8];
      end
   end

   // Pad values for the current phase; ad and bus hold their last value outside ADDR/DATA.
   always_comb begin
      strobe_d = STROBE_IDLE;
      ad_d     = ad_o;
      oe_d     = 1'b0;
      bus_d    = bus_o;
      case (state_q)
         ST_ADDR: begin
            strobe_d = 3'b010;
            ad_d     = 1'b0;
            oe_d     = 1'b1;
            bus_d    = addr_q;
         end
         ST_DATA: begin
            ad_d = 1'b1;
            if (rnw_q) begin
               strobe_d = 3'b001;
            end else begin
               strobe_d = 3'b010;
               oe_d     = 1'b1;
               bus_d    = wdata_q;
            end
         end
         default: ;
      endcase
   end

   // Registered outputs; read data is taken at the end of the last visible DATA cycle.
   always_ff @(posedge clk_i or negedge reset) begin
      if (!reset) begin
         gnt_o       <= 3'b000;
         done_o      <= 3'b000;
         rdata_o     <= 8'h00;
         busy_o      <= 1'b0;
         bus_o       <= 8'h00;
         bus_oe_o    <= 1'b0;
         ad_o        <= 1'b0;
         cs_o        <= 1'b1;
         rd_o        <= 1'b1;
         wr_o        <= 1'b1;
         last_data_q <= 1'b0;
      end else begin
         {cs_o, rd_o, wr_o} <= strobe_d;
         ad_o        <= ad_d;
         bus_oe_o    <= oe_d;
         bus_o       <= bus_d;
         busy_o      <= (state_q != ST_IDLE);
         gnt_o       <= (state_q != ST_IDLE) ? gnt_q : 3'b000;
         done_o      <= (state_q == ST_DONE) ? gnt_q : 3'b000;
         last_data_q <= (state_q == ST_DATA) && phase_end;
         if (last_data_q && rnw_q) rdata_o <= bus_i;
      end
   end

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Self-checking bench for rtc_bus_scheduler: a default-timing instance and a
// T_PULSE = T_GAP = 1 instance, checked cycle by cycle against a timeline
// model built from the phase lengths and the arbitration rules.
module tb_rtc_bus_scheduler;

   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic        reset;
   logic [2:0]  req_q, rnw_q;
   logic [23:0] addr_q, wdata_q;
   logic [7:0]  bus_i;
   logic        sel_fast;
   logic [2:0]  req_m, req_f;

   assign req_m = sel_fast ? 3'b000 : req_q;
   assign req_f = sel_fast ? req_q : 3'b000;

   logic [2:0] m_gnt, m_done, f_gnt, f_done;
   logic [7:0] m_rdata, m_bus, f_rdata, f_bus;
   logic       m_busy, m_oe, m_ad, m_cs, m_rd, m_wr;
   logic       f_busy, f_oe, f_ad, f_cs, f_rd, f_wr;

   rtc_bus_scheduler #(.T_PULSE(7), .T_GAP(7)) dut (
      .clk_i(clk_i), .reset(reset), .req_i(req_m), .rnw_i(rnw_q),
      .addr_i(addr_q), .wdata_i(wdata_q), .gnt_o(m_gnt), .done_o(m_done),
      .rdata_o(m_rdata), .busy_o(m_busy), .bus_o(m_bus), .bus_oe_o(m_oe),
      .bus_i(bus_i), .ad_o(m_ad), .cs_o(m_cs), .rd_o(m_rd), .wr_o(m_wr)
   );

   rtc_bus_scheduler #(.T_PULSE(1), .T_GAP(1)) dut_fast (
      .clk_i(clk_i), .reset(reset), .req_i(req_f), .rnw_i(rnw_q),
      .addr_i(addr_q), .wdata_i(wdata_q), .gnt_o(f_gnt), .done_o(f_done),
      .rdata_o(f_rdata), .busy_o(f_busy), .bus_o(f_bus), .bus_oe_o(f_oe),
      .bus_i(bus_i), .ad_o(f_ad), .cs_o(f_cs), .rd_o(f_rd), .wr_o(f_wr)
   );

   // Observed outputs of whichever instance is under test.
   logic [2:0] o_gnt, o_done;
   logic [7:0] o_rdata, o_bus;
   logic       o_busy, o_oe, o_ad, o_cs, o_rd, o_wr;
   assign o_gnt   = sel_fast ? f_gnt   : m_gnt;
   assign o_done  = sel_fast ? f_done  : m_done;
   assign o_rdata = sel_fast ? f_rdata : m_rdata;
   assign o_bus   = sel_fast ? f_bus   : m_bus;
   assign o_busy  = sel_fast ? f_busy  : m_busy;
   assign o_oe    = sel_fast ? f_oe    : m_oe;
   assign o_ad    = sel_fast ? f_ad    : m_ad;
   assign o_cs    = sel_fast ? f_cs    : m_cs;
   assign o_rd    = sel_fast ? f_rd    : m_rd;
   assign o_wr    = sel_fast ? f_wr    : m_wr;

   int         n_checks = 0;
   int         n_errors = 0;
   int         tp = 7;
   int         tg = 7;
   int         fav_m = 1;      // port (1 or 2) favoured on a 1-vs-2 tie
   logic [7:0] rdata_m = 8'h00;
   logic [7:0] rd_val = 8'h00;

   // Pad model: the addressed register drives rd_val while RD is low, noise otherwise.
   always @(negedge clk_i) bus_i = (o_rd == 1'b0) ? rd_val : 8'($urandom);

   // Arbitration reference: port 0 first; 1 vs 2 goes to the favoured one; the winner
   // among 1/2 hands the favour to the other.
   function automatic int model_pick(input logic [2:0] r);
      int p;
      p = -1;
      if (r[0])              p = 0;
      else if (r[1] && r[2]) p = fav_m;
      else if (r[1])         p = 1;
      else if (r[2])         p = 2;
      if (p == 1 || p == 2) fav_m = 3 - p;
      return p;
   endfunction

   // Runs one transaction from the negedge where the requests are set up to the
   // negedge where done_o is seen, comparing every cycle against the timeline.
   task automatic do_txn(input string name, input logic [2:0] drop_mask,
                         input logic [7:0] rdv, output int got);
      int p, w, len;
      logic e_rnw, e_ad, e_oe;
      logic [7:0] e_addr, e_wd, e_bus, e_rdata;
      logic [2:0] e_str, e_done, e_gnt;
      logic [27:0] a_vec, e_vec;
      p = model_pick(req_q);
      if (p < 0) p = 0;
      e_rnw  = rnw_q[p];
      e_addr = addr_q[8*p +: 8];
      e_wd   = wdata_q[8*p +: 8];
      e_gnt  = 3'(1 << p);
      rd_val = rdv;
      w = 0;
      do begin
         @(negedge clk_i);
         w++;
      end while (o_gnt == 3'b000 && w < 8);
      n_checks++;
      if (w !== 2) begin
         n_errors++;
         $display("FAIL %s grant_latency: got %0d cycles, expected 2", name, w);
      end
      got = (o_gnt == 3'b001) ? 0 : (o_gnt == 3'b010) ? 1 : (o_gnt == 3'b100) ? 2 : -1;
      // Inputs change after the grant; the transaction must keep its captured values.
      rnw_q   = 3'($urandom);
      addr_q  = 24'($urandom);
      wdata_q = 24'($urandom);
      len = 2 * (tp + tg) + 1;
      for (int k = 1; k <= len; k++) begin
         if (k > 1) @(negedge clk_i);
         e_done = 3'b000;
         e_oe   = 1'b0;
         e_bus  = 8'h00;
         e_str  = 3'b111;
         e_ad   = 1'b0;
         if (k <= tp) begin
            e_str = 3'b010; e_oe = 1'b1; e_bus = e_addr;
         end else if (k <= tp + tg) begin
            e_ad = 1'b0;
         end else if (k <= 2 * tp + tg) begin
            e_ad = 1'b1;
            if (e_rnw) e_str = 3'b001;
            else begin e_str = 3'b010; e_oe = 1'b1; e_bus = e_wd; end
         end else begin
            e_ad = 1'b1;
            if (k == len) e_done = e_gnt;
         end
         e_rdata = (e_rnw && k >= 2 * tp + tg + 1) ? rd_val : rdata_m;
         e_vec = {e_gnt, e_done, 1'b1, e_str, e_ad, e_oe, e_bus, e_rdata};
         a_vec = {o_gnt, o_done, o_busy, o_cs, o_rd, o_wr, o_ad, o_oe,
                  (e_oe ? o_bus : 8'h00), o_rdata};
         n_checks++;
         if (a_vec !== e_vec) begin
            n_errors++;
            $display("FAIL %s cycle %0d {gnt,done,busy,cs,rd,wr,ad,oe,bus,rdata}: got %h expected %h",
                     name, k, a_vec, e_vec);
         end
      end
      if (e_rnw) rdata_m = rd_val;
      if (drop_mask[p]) req_q[p] = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; sel_fast = 1'b0; req_q = 3'b000; rnw_q = 3'b000;
      addr_q = 24'h0; wdata_q = 24'h0;
      repeat (2) @(negedge clk_i);
      n_checks++;
      if ({m_gnt, m_done, m_busy, m_cs, m_rd, m_wr, m_ad, m_oe, m_bus, m_rdata} !==
          {3'b000, 3'b000, 1'b0, 3'b111, 1'b0, 1'b0, 8'h00, 8'h00}) begin
         n_errors++;
         $display("FAIL reset_main: got %h", {m_gnt, m_done, m_busy, m_cs, m_rd, m_wr, m_ad, m_oe, m_bus, m_rdata});
      end
      n_checks++;
      if ({f_gnt, f_done, f_busy, f_cs, f_rd, f_wr, f_ad, f_oe, f_bus, f_rdata} !==
          {3'b000, 3'b000, 1'b0, 3'b111, 1'b0, 1'b0, 8'h00, 8'h00}) begin
         n_errors++;
         $display("FAIL reset_fast: got %h", {f_gnt, f_done, f_busy, f_cs, f_rd, f_wr, f_ad, f_oe, f_bus, f_rdata});
      end
      reset = 1'b1;
      repeat (2) @(negedge clk_i);
      n_checks++;
      if ({m_busy, m_gnt, m_cs} !== {1'b0, 3'b000, 1'b1}) begin
         n_errors++;
         $display("FAIL idle_no_req: got busy/gnt/cs %h expected 0/0/1", {m_busy, m_gnt, m_cs});
      end
   endtask

   task automatic test_write_port1();
      int got;
      req_q = 3'b010; rnw_q = 3'b000;
      addr_q = 24'h00_21_00; wdata_q = 24'h00_00_00;
      do_txn("write_p1", 3'b010, 8'h00, got);
      n_checks++;
      if (got !== 1) begin n_errors++; $display("FAIL write_p1_port: got %0d expected 1", got); end
   endtask

   task automatic test_read_port2();
      int got;
      repeat (3) @(negedge clk_i);
      req_q = 3'b100; rnw_q = 3'b100;
      addr_q = 24'h23_00_00; wdata_q = 24'h5a_00_00;
      do_txn("read_p2", 3'b100, 8'h14, got);
      n_checks++;
      if (o_rdata !== 8'h14) begin n_errors++; $display("FAIL read_p2_rdata: got %h expected 14", o_rdata); end
   endtask

   task automatic test_priority();
      int got;
      int seq_b[4] = '{0, 1, 2, 1};
      repeat (3) @(negedge clk_i);
      req_q = 3'b111;
      for (int i = 0; i < 3; i++) begin
         do_txn("prio_a", 3'b111, 8'($urandom), got);
         n_checks++;
         if (got !== i) begin n_errors++; $display("FAIL prio_a_order[%0d]: got %0d expected %0d", i, got, i); end
      end
      req_q = 3'b111;
      for (int i = 0; i < 4; i++) begin
         do_txn("prio_b", 3'b001, 8'($urandom), got);
         n_checks++;
         if (got !== seq_b[i]) begin
            n_errors++;
            $display("FAIL prio_b_order[%0d]: got %0d expected %0d", i, got, seq_b[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int got, prev;
      prev = 1;   // last grant of test_priority
      req_q = 3'b110;
      for (int i = 0; i < 4; i++) begin
         do_txn("rr12", 3'b000, 8'($urandom), got);
         n_checks++;
         if (got == prev || (got != 1 && got != 2)) begin
            n_errors++;
            $display("FAIL rr12_alternate[%0d]: got %0d after %0d", i, got, prev);
         end
         prev = got;
      end
      req_q = 3'b000;
   endtask

   task automatic test_reset_mid();
      int w;
      repeat (3) @(negedge clk_i);
      req_q = 3'b010; rnw_q = 3'b000;
      addr_q = 24'h00_42_00; wdata_q = 24'h00_99_00;
      w = 0;
      do begin @(negedge clk_i); w++; end while (o_gnt == 3'b000 && w < 8);
      repeat (tp + tg + 1) @(negedge clk_i);
      n_checks++;
      if ({o_wr, o_ad, o_oe} !== 3'b011) begin
         n_errors++;
         $display("FAIL mid_in_data: got wr/ad/oe %b expected 011", {o_wr, o_ad, o_oe});
      end
      reset = 1'b0;
      #1;
      n_checks++;
      if ({o_gnt, o_done, o_busy, o_cs, o_rd, o_wr, o_ad, o_oe, o_bus, o_rdata} !==
          {3'b000, 3'b000, 1'b0, 3'b111, 1'b0, 1'b0, 8'h00, 8'h00}) begin
         n_errors++;
         $display("FAIL mid_reset_outputs: got %h", {o_gnt, o_done, o_busy, o_cs, o_rd, o_wr, o_ad, o_oe, o_bus, o_rdata});
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         n_checks++;
         if ({o_done, o_gnt} !== 6'b0) begin
            n_errors++;
            $display("FAIL mid_reset_hold[%0d]: got done/gnt %b expected 0", i, {o_done, o_gnt});
         end
      end
      reset = 1'b1;
      fav_m = 1;
      rdata_m = 8'h00;
      addr_q = 24'h00_42_00; wdata_q = 24'h00_99_00; rnw_q = 3'b000;
      do_txn("after_reset", 3'b010, 8'h00, w);
   endtask

   task automatic test_random();
      int got;
      req_q = 3'b000;
      for (int i = 0; i < 20; i++) begin
         req_q = req_q | 3'($urandom);
         if (req_q == 3'b000) req_q[$urandom_range(2, 0)] = 1'b1;
         rnw_q = 3'($urandom); addr_q = 24'($urandom); wdata_q = 24'($urandom);
         do_txn("random", 3'($urandom) | 3'b001, 8'($urandom), got);
      end
      req_q = 3'b000;
      repeat (3) @(negedge clk_i);
      n_checks++;
      if ({o_busy, o_gnt, o_done} !== 7'b0) begin
         n_errors++;
         $display("FAIL random_idle_after: got busy/gnt/done %b expected 0", {o_busy, o_gnt, o_done});
      end
   endtask

   task automatic test_fast();
      int got;
      sel_fast = 1'b1;
      tp = 1; tg = 1;
      fav_m = 1;
      rdata_m = 8'h00;
      @(negedge clk_i);
      req_q = 3'b001; rnw_q = 3'b000;
      addr_q = 24'h00_00_3c; wdata_q = 24'h00_00_c3;
      do_txn("fast_p0", 3'b001, 8'h00, got);
      n_checks++;
      if (got !== 0) begin n_errors++; $display("FAIL fast_port: got %0d expected 0", got); end
      @(negedge clk_i);
      n_checks++;
      if ({o_busy, o_gnt, o_done} !== 7'b0) begin
         n_errors++;
         $display("FAIL fast_idle_after: got busy/gnt/done %b expected 0", {o_busy, o_gnt, o_done});
      end
   endtask

   initial begin
      test_reset();
      test_write_port1();
      test_read_port2();
      test_priority();
      test_back_to_back();
      test_reset_mid();
      test_random();
      test_fast();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
